// File: rtl/key_encoder.sv
// key_encoder: synchronise, debounce and encode five pushbuttons into one-cycle key codes with auto-repeat
module key_encoder #(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000,
  parameter int CNT_W           = 25
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_select,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  typedef enum logic [1:0] {IDLE, HOLD, REPEAT, WAIT_REL} state_t;
  state_t state, state_n;
  logic [4:0] raw, s1, s2, st, cur, hv, hv_n;
  logic [CNT_W-1:0] rcnt, rcnt_n, lim;
  logic [3:0] enc, code_n;
  logic single;
  assign raw = {btn_select, btn_right, btn_up, btn_left, btn_down};
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  for (genvar b = 0; b < 5; b++) begin : g_db
    logic stb;
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clock or posedge reset)
      if (reset) begin
        stb <= 1'b0;
        cnt <= '0;
      end else if (s2[b] == stb) cnt <= '0;
      else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stb <= s2[b];
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    assign st[b] = stb;
  end
  assign key_held = |st;
  assign single = (cur != 5'd0) && ((cur & (cur - 5'd1)) == 5'd0);
  assign enc = cur[0] ? 4'd1 : cur[1] ? 4'd2 : cur[2] ? 4'd3 : cur[3] ? 4'd4 : cur[4] ? 4'd5 : 4'd0;
  assign lim = (state == HOLD) ? CNT_W'(REPEAT_DELAY - 1) : CNT_W'(REPEAT_PERIOD - 1);
  always_comb begin
    state_n = state;
    rcnt_n  = rcnt;
    hv_n    = hv;
    code_n  = 4'd0;
    case (state)
      IDLE:
        if (single) begin
          code_n  = enc;
          hv_n    = cur;
          rcnt_n  = '0;
          state_n = HOLD;
        end else if (cur != 5'd0) state_n = WAIT_REL;
      HOLD, REPEAT:
        if (cur != hv) state_n = (cur == 5'd0) ? IDLE : WAIT_REL;
        // select is held without repeating and its counter stays put
        else if (!hv[4]) begin
          if (rcnt == lim) begin
            code_n  = enc;
            rcnt_n  = '0;
            state_n = REPEAT;
          end else rcnt_n = rcnt + 1'b1;
        end
      WAIT_REL: state_n = (cur == 5'd0) ? IDLE : WAIT_REL;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state     <= IDLE;
      cur       <= '0;
      hv        <= '0;
      rcnt      <= '0;
      key_code  <= 4'd0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_n;
      cur       <= st;
      hv        <= hv_n;
      rcnt      <= rcnt_n;
      key_code  <= code_n;
      key_valid <= code_n != 4'd0;
    end
endmodule

// File: tb/tb_key_encoder.sv
// tb_key_encoder: directed button scenarios with a queued scoreboard of expected key pulses
module tb_key_encoder;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] b;
  logic [3:0] key_code;
  logic key_valid, key_held;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int qc[$];
  int qt[$];
  int c, r;
  key_encoder #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8), .CNT_W(8)) dut (
    .clock(clk), .reset(reset),
    .btn_down(b[0]), .btn_left(b[1]), .btn_up(b[2]), .btn_right(b[3]), .btn_select(b[4]),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    checks++;
    if (key_valid !== (key_code != 4'd0)) begin
      errors++;
      $display("FAIL valid_vs_code cyc=%0d key_valid=%b key_code=%0d", cyc, key_valid, key_code);
    end
    if (key_code != 4'd0) begin
      checks++;
      if (qc.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got code=%0d expected none", cyc, key_code);
      end else begin
        int ec, et;
        ec = qc.pop_front();
        et = qt.pop_front();
        if (int'(key_code) != ec || cyc != et) begin
          errors++;
          $display("FAIL pulse got code=%0d at cyc=%0d expected code=%0d at cyc=%0d", key_code, cyc, ec, et);
        end
      end
    end
  end
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input int code, input int t);
    qc.push_back(code);
    qt.push_back(t);
  endtask
  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    b = '0;
    step(3);
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      chk("idle_held", {3'b0, key_held}, 4'd0);
    end
    b[3] = 1'b1;
    step(3);
    b[3] = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      chk("glitch_held", {3'b0, key_held}, 4'd0);
    end
    c = cyc;
    b[0] = 1'b1;
    push(1, c + 8);
    step(9);
    chk("down_held", {3'b0, key_held}, 4'd1);
    step(1);
    b[0] = 1'b0;
    step(10);
    chk("down_released", {3'b0, key_held}, 4'd0);
    step(5);
    c = cyc;
    b[1] = 1'b1;
    push(2, c + 8);
    push(2, c + 28);
    push(2, c + 36);
    push(2, c + 44);
    step(40);
    b[1] = 1'b0;
    step(20);
    c = cyc;
    b[4] = 1'b1;
    push(5, c + 8);
    step(60);
    b[4] = 1'b0;
    step(20);
    c = cyc;
    b[2] = 1'b1;
    push(3, c + 8);
    step(12);
    b[3] = 1'b1;
    step(20);
    b[3] = 1'b0;
    step(20);
    chk("up_alone_held", {3'b0, key_held}, 4'd1);
    b[2] = 1'b0;
    step(20);
    c = cyc;
    b[2] = 1'b1;
    push(3, c + 8);
    step(15);
    b[2] = 1'b0;
    step(20);
    b[0] = 1'b1;
    b[1] = 1'b1;
    step(30);
    chk("simul_held", {3'b0, key_held}, 4'd1);
    b[0] = 1'b0;
    b[1] = 1'b0;
    step(20);
    c = cyc;
    b[1] = 1'b1;
    push(2, c + 8);
    step(28);
    chk("pre_reset_code", key_code, 4'd2);
    reset = 1'b1;
    #1;
    chk("reset_code", key_code, 4'd0);
    chk("reset_valid", {3'b0, key_valid}, 4'd0);
    chk("reset_held", {3'b0, key_held}, 4'd0);
    step(3);
    reset = 1'b0;
    r = cyc;
    push(2, r + 8);
    step(20);
    b[1] = 1'b0;
    step(20);
    checks++;
    if (qc.size() != 0) begin
      errors++;
      $display("FAIL missing_pulses got=%0d pending expected=0, next code=%0d at cyc=%0d", qc.size(), qc[0], qt[0]);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
